// File: rtl/sub64_seq.sv
// Multi-cycle signed subtractor: diff = a + ~b + 1, one CHUNK-bit slice per clock,
// with Y86 ZF/SF/OF flags and a start/busy/done handshake.
module sub64_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] diff,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic             a_msb, b_msb;
  logic [CHUNK:0]   slice;
  logic             accept, last;

  // Signed overflow of a - b: operands differ in sign and result sign leaves a's.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic rm);
    return (am != bm) && (rm != am);
  endfunction

  assign busy   = (state == RUN);
  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(NCHUNK - 1));

  always_comb begin
    slice   = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    res_nxt = {slice[CHUNK-1:0], res[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      zf    <= 1'b0;
      sf    <= 1'b0;
      of    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= ~b;
        carry <= 1'b1;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        res   <= res_nxt;
        opa   <= opa >> CHUNK;
        opb   <= opb >> CHUNK;
        carry <= slice[CHUNK];
        cnt   <= cnt + CW'(1);
        // Final slice: publish result and flags; the carry-out is dropped.
        if (last) begin
          done <= 1'b1;
          diff <= res_nxt;
          zf   <= (res_nxt == '0);
          sf   <= res_nxt[WIDTH-1];
          of   <= sub_ovf(a_msb, b_msb, res_nxt[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_sub64_seq.sv
// Directed bench for sub64_seq: cycle-by-cycle compare against a transaction-level
// model plus hand-computed literal expectations.
module tb_sub64_seq;

  localparam int W  = 64;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [W-1:0]  a, b;
  logic          busy, done, zf, sf, of;
  logic [W-1:0]  diff;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  sub64_seq #(.WIDTH(W), .CHUNK(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  // Model: an accepted op completes NC edges later with a - b and its flags.
  int           rem;
  logic         m_done, m_zf, m_sf, m_of, p_of;
  logic [W-1:0] m_diff, p_diff;
  logic         m_busy;
  logic signed [W:0] wide;

  assign m_busy = (rem != 0);
  assign wide   = $signed({a[W-1], a}) - $signed({b[W-1], b});

  always @(posedge clk) begin
    if (!rst_n) begin
      rem <= 0; m_done <= 1'b0; m_diff <= '0;
      m_zf <= 1'b0; m_sf <= 1'b0; m_of <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (rem != 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_diff <= p_diff;
          m_zf   <= (p_diff == '0);
          m_sf   <= p_diff[W-1];
          m_of   <= p_of;
        end
      end else if (start) begin
        rem    <= NC;
        p_diff <= a - b;
        p_of   <= (wide[W] != wide[W-1]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (busy !== m_busy || done !== m_done || diff !== m_diff ||
          zf !== m_zf || sf !== m_sf || of !== m_of) begin
        fails++;
        $display("FAIL model_cmp t=%0t got busy=%b done=%b diff=%h zf=%b sf=%b of=%b want busy=%b done=%b diff=%h zf=%b sf=%b of=%b",
                 $time, busy, done, diff, zf, sf, of, m_busy, m_done, m_diff, m_zf, m_sf, m_of);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the done cycle.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic ez, input logic es, input logic eo);
    int n = 0;
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = '1; b = '1;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
    chk({name, "_lat"}, 64'(n), 64'(NC));
    chk({name, "_diff"}, diff, ed);
    chk({name, "_zf"}, 64'(zf), 64'(ez));
    chk({name, "_sf"}, 64'(sf), 64'(es));
    chk({name, "_of"}, 64'(of), 64'(eo));
  endtask

  initial begin
    int n;
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {61'd0, zf, sf, of}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("p5m3",  64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);
    run_op("p3m5",  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
    run_op("eq23",  64'd23, 64'd23, 64'd0, 1'b1, 1'b0, 1'b0);
    run_op("ovneg", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("ovpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    run_op("borrow", 64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("wrap",  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Handshake: start held high; operands changed mid-run must be ignored.
    a = 64'd10; b = 64'd4; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 3) a = 64'd99;
      if (i == 8) begin
        chk("hs1_done", 64'(done), 64'd1);
        chk("hs1_diff", diff, 64'd6);
      end
      if (i == 9) begin
        start = 1'b0;
        chk("hs2_busy", 64'(busy), 64'd1);
        chk("hs2_keep", diff, 64'd6);
      end
      if (i == 17) begin
        chk("hs2_done", 64'(done), 64'd1);
        chk("hs2_diff", diff, 64'd95);
      end
    end

    // Reset mid-operation aborts with no done pulse.
    a = 64'd7; b = 64'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_diff", diff, 64'd0);
    seen_done = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (done) seen_done = 1'b1;
    end
    chk("mid_nodone", 64'(seen_done), 64'd0);
    run_op("after", 64'd7, 64'd2, 64'd5, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
